// File: rtl/acq_readout_sched_if.sv
// RAM and outbound TX byte channel bundle of the acquisition/readout controller.
// The TX channel is valid/ready style: a byte moves on the edge where tx_rdy_o and tx_ack_i are both high.
interface acq_readout_sched_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int RAM_ADDR_WIDTH = 10
);
    logic                      wr_en_o;
    logic [RAM_ADDR_WIDTH-1:0] wr_addr_o;
    logic [RAM_ADDR_WIDTH-1:0] rd_addr_o;
    logic [DATA_WIDTH-1:0]     rd_data_ch1_i;
    logic [DATA_WIDTH-1:0]     rd_data_ch2_i;
    logic [DATA_WIDTH-1:0]     tx_data_o;
    logic                      tx_rdy_o;
    logic                      tx_ack_i;

    modport master (
        output wr_en_o, wr_addr_o, rd_addr_o, tx_data_o, tx_rdy_o,
        input  rd_data_ch1_i, rd_data_ch2_i, tx_ack_i
    );

    modport slave (
        input  wr_en_o, wr_addr_o, rd_addr_o, tx_data_o, tx_rdy_o,
        output rd_data_ch1_i, rd_data_ch2_i, tx_ack_i
    );
endinterface

// File: rtl/acq_readout_sched.sv
// Acquisition FSM owning the circular RAM write address, plus a readout FSM that
// serialises trigger status, CH1 and CH2 records onto the single TX byte channel.
module acq_readout_sched #(
    parameter int DATA_WIDTH     = 8,
    parameter int RAM_ADDR_WIDTH = 10,
    parameter int POST_TRIG      = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       rqst_ch1_i,
    input  logic       rqst_ch2_i,
    input  logic       rqst_trig_i,
    input  logic       reset_i,
    input  logic       sample_en_i,
    input  logic       trigger_i,
    output logic       busy_o,
    output logic [1:0] acq_state_o,
    output logic [2:0] rd_state_o,
    acq_readout_sched_if.master bus
);
    localparam int AW = RAM_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int CW = RAM_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] POST_TRIG_C = CW'(POST_TRIG);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] TRIG = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] R_IDLE = 3'd0;
    localparam logic [2:0] R_STAT = 3'd1;
    localparam logic [2:0] R_ADDR = 3'd2;
    localparam logic [2:0] R_WAIT = 3'd3;
    localparam logic [2:0] R_SEND = 3'd4;

    logic [1:0]    acq_q, acq_d;
    logic          triggered_q, triggered_d;
    logic [CW-1:0] post_cnt_q, post_cnt_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [2:0]    rd_q, rd_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] smp_cnt_q, smp_cnt_d;
    logic          sel_ch2_q, sel_ch2_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          tx_rdy_q, tx_rdy_d;
    logic          p_trig_q, p_trig_d;
    logic          p_ch1_q, p_ch1_d;
    logic          p_ch2_q, p_ch2_d;

    logic          clear;
    logic          busy;
    logic          wr_en;
    logic          acq_quiet;
    logic [DW-1:0] stat_byte;

    assign clear     = rst | reset_i;
    assign busy      = (rd_q != R_IDLE);
    assign wr_en     = sample_en_i && ((acq_q == RUN) || (acq_q == TRIG));
    assign acq_quiet = (acq_q == IDLE) || (acq_q == DONE);

    always_comb begin
        acq_d       = acq_q;
        triggered_d = triggered_q;
        post_cnt_d  = post_cnt_q;
        wr_addr_d   = wr_en ? wr_addr_q + 1'b1 : wr_addr_q;
        case (acq_q)
            IDLE, DONE: begin
                if (start_i && !busy) begin
                    acq_d       = RUN;
                    triggered_d = 1'b0;
                end
            end
            RUN: begin
                if (stop_i) begin
                    acq_d = IDLE;
                end else if (trigger_i) begin
                    acq_d       = TRIG;
                    triggered_d = 1'b1;
                    post_cnt_d  = '0;
                end
            end
            TRIG: begin
                // stop wins over a completing post-trigger write
                if (stop_i) begin
                    acq_d = IDLE;
                end else if (sample_en_i) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_d == POST_TRIG_C) acq_d = DONE;
                end
            end
            default: acq_d = IDLE;
        endcase
    end

    always_comb begin
        stat_byte    = '0;
        stat_byte[0] = (acq_q == RUN) || (acq_q == TRIG);
        stat_byte[1] = triggered_q;
        stat_byte[2] = (acq_q == DONE);
    end

    // A flag is consumed when its service begins, so a pulse arriving during
    // service leaves it set and the item is served once more afterwards.
    always_comb begin
        rd_d      = rd_q;
        rd_addr_d = rd_addr_q;
        smp_cnt_d = smp_cnt_q;
        sel_ch2_d = sel_ch2_q;
        tx_data_d = tx_data_q;
        tx_rdy_d  = tx_rdy_q;
        p_trig_d  = p_trig_q | rqst_trig_i;
        p_ch1_d   = p_ch1_q | rqst_ch1_i;
        p_ch2_d   = p_ch2_q | rqst_ch2_i;
        case (rd_q)
            R_IDLE: begin
                // Status never touches the RAM, so it is served in any acquisition state.
                if (p_trig_q) begin
                    rd_d      = R_STAT;
                    tx_data_d = stat_byte;
                    tx_rdy_d  = 1'b1;
                    p_trig_d  = rqst_trig_i;
                end else if (acq_quiet && (p_ch1_q || p_ch2_q)) begin
                    rd_d      = R_ADDR;
                    rd_addr_d = wr_addr_q;
                    smp_cnt_d = '0;
                    sel_ch2_d = !p_ch1_q;
                    if (p_ch1_q) p_ch1_d = rqst_ch1_i;
                    else         p_ch2_d = rqst_ch2_i;
                end
            end
            R_STAT: begin
                if (bus.tx_ack_i) begin
                    rd_d     = R_IDLE;
                    tx_rdy_d = 1'b0;
                end
            end
            R_ADDR: rd_d = R_WAIT;
            R_WAIT: begin
                rd_d      = R_SEND;
                tx_data_d = sel_ch2_q ? bus.rd_data_ch2_i : bus.rd_data_ch1_i;
                tx_rdy_d  = 1'b1;
            end
            R_SEND: begin
                if (bus.tx_ack_i) begin
                    tx_rdy_d  = 1'b0;
                    rd_addr_d = rd_addr_q + 1'b1;
                    smp_cnt_d = smp_cnt_q + 1'b1;
                    rd_d      = (smp_cnt_q == '1) ? R_IDLE : R_ADDR;
                end
            end
            default: begin
                rd_d     = R_IDLE;
                tx_rdy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            acq_q       <= IDLE;
            triggered_q <= 1'b0;
            post_cnt_q  <= '0;
            wr_addr_q   <= '0;
            rd_q        <= R_IDLE;
            rd_addr_q   <= '0;
            smp_cnt_q   <= '0;
            sel_ch2_q   <= 1'b0;
            tx_data_q   <= '0;
            tx_rdy_q    <= 1'b0;
            p_trig_q    <= 1'b0;
            p_ch1_q     <= 1'b0;
            p_ch2_q     <= 1'b0;
        end else begin
            acq_q       <= acq_d;
            triggered_q <= triggered_d;
            post_cnt_q  <= post_cnt_d;
            wr_addr_q   <= wr_addr_d;
            rd_q        <= rd_d;
            rd_addr_q   <= rd_addr_d;
            smp_cnt_q   <= smp_cnt_d;
            sel_ch2_q   <= sel_ch2_d;
            tx_data_q   <= tx_data_d;
            tx_rdy_q    <= tx_rdy_d;
            p_trig_q    <= p_trig_d;
            p_ch1_q     <= p_ch1_d;
            p_ch2_q     <= p_ch2_d;
        end
    end

    assign bus.wr_en_o   = wr_en;
    assign bus.wr_addr_o = wr_addr_q;
    assign bus.rd_addr_o = rd_addr_q;
    assign bus.tx_data_o = tx_data_q;
    assign bus.tx_rdy_o  = tx_rdy_q;
    assign busy_o        = busy;
    assign acq_state_o   = acq_q;
    assign rd_state_o    = rd_q;
endmodule

// File: tb/tb_acq_readout_sched.sv
// Directed bench for acq_readout_sched with an 8-entry two-channel RAM model.
module tb_acq_readout_sched;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int PT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0, stop_i = 1'b0, rqst_ch1_i = 1'b0, rqst_ch2_i = 1'b0;
    logic rqst_trig_i = 1'b0, reset_i = 1'b0, sample_en_i = 1'b0, trigger_i = 1'b0;
    logic       busy_o;
    logic [1:0] acq_state_o;
    logic [2:0] rd_state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acq_readout_sched_if #(.DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW)) bus ();

    acq_readout_sched #(.DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .POST_TRIG(PT)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
        .rqst_ch1_i(rqst_ch1_i), .rqst_ch2_i(rqst_ch2_i), .rqst_trig_i(rqst_trig_i),
        .reset_i(reset_i), .sample_en_i(sample_en_i), .trigger_i(trigger_i),
        .busy_o(busy_o), .acq_state_o(acq_state_o), .rd_state_o(rd_state_o), .bus(bus)
    );

    // RAM model: ch1 stores 0x10+n, ch2 stores 0x80+n for ADC sample n; one-cycle read latency.
    logic [DW-1:0] mem1 [0:(1<<AW)-1];
    logic [DW-1:0] mem2 [0:(1<<AW)-1];
    logic [DW-1:0] adc_val = '0;
    always @(posedge clk) begin
        if (bus.wr_en_o) begin
            mem1[bus.wr_addr_o] <= 8'h10 + adc_val;
            mem2[bus.wr_addr_o] <= 8'h80 + adc_val;
        end
        bus.rd_data_ch1_i <= mem1[bus.rd_addr_o];
        bus.rd_data_ch2_i <= mem2[bus.rd_addr_o];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // m = {reset_i, rqst_trig_i, rqst_ch2_i, rqst_ch1_i, stop_i, start_i}
    task automatic pulse(input logic [5:0] m);
        {reset_i, rqst_trig_i, rqst_ch2_i, rqst_ch1_i, stop_i, start_i} = m;
        tick();
        {reset_i, rqst_trig_i, rqst_ch2_i, rqst_ch1_i, stop_i, start_i} = '0;
    endtask

    task automatic sample(input int v);
        adc_val = v[DW-1:0];
        sample_en_i = 1'b1;
        tick();
        sample_en_i = 1'b0;
    endtask

    task automatic recv(input int stall, output logic [DW-1:0] d, output logic [AW-1:0] a,
                        output int waits, output logic stable);
        waits = 0;
        stable = 1'b1;
        d = '0;
        a = '0;
        while (bus.tx_rdy_o !== 1'b1 && waits < 40) begin
            tick();
            waits++;
        end
        checks++;
        if (bus.tx_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL recv_timeout: tx_rdy_o=%b after %0d cycles, required 1", bus.tx_rdy_o, waits);
        end else begin
            d = bus.tx_data_o;
            a = bus.rd_addr_o;
            repeat (stall) begin
                tick();
                if (bus.tx_data_o !== d || bus.rd_addr_o !== a || bus.tx_rdy_o !== 1'b1) stable = 1'b0;
            end
            bus.tx_ack_i = 1'b1;
            tick();
            bus.tx_ack_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        sample_en_i = 1'b1;
        repeat (3) tick();
        checks += 8;
        if (bus.wr_en_o !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", bus.wr_en_o); end
        if (bus.wr_addr_o !== 3'd0) begin errors++; $display("FAIL rst_wr_addr: got %0d want 0", bus.wr_addr_o); end
        if (bus.rd_addr_o !== 3'd0) begin errors++; $display("FAIL rst_rd_addr: got %0d want 0", bus.rd_addr_o); end
        if (bus.tx_data_o !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", bus.tx_data_o); end
        if (bus.tx_rdy_o !== 1'b0) begin errors++; $display("FAIL rst_tx_rdy: got %b want 0", bus.tx_rdy_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        if (acq_state_o !== 2'd0) begin errors++; $display("FAIL rst_acq_state: got %0d want 0", acq_state_o); end
        if (rd_state_o !== 3'd0) begin errors++; $display("FAIL rst_rd_state: got %0d want 0", rd_state_o); end
        rst = 1'b0;
        sample_en_i = 1'b0;
        tick();
    endtask

    task automatic test_status();
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int w;
        logic st;
        pulse(6'b000001);
        pulse(6'b010000);
        recv(0, d, a, w, st);
        checks += 3;
        if (d !== 8'h01) begin errors++; $display("FAIL stat_run: got %h want 01", d); end
        if (w !== 1) begin errors++; $display("FAIL stat_latency: got %0d want 1 extra cycle", w); end
        tick();
        if (bus.tx_rdy_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL stat_single: tx_rdy=%b busy=%b want 0 0", bus.tx_rdy_o, busy_o);
        end
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        pulse(6'b010000);
        recv(0, d, a, w, st);
        checks++;
        if (d !== 8'h03) begin errors++; $display("FAIL stat_trig: got %h want 03", d); end
        for (int k = 0; k < PT - 1; k++) sample(k);
        checks++;
        if (acq_state_o !== 2'd2) begin errors++; $display("FAIL post_trig_short: state %0d want 2", acq_state_o); end
        sample(PT - 1);
        checks += 2;
        if (acq_state_o !== 2'd3) begin errors++; $display("FAIL post_trig_done: state %0d want 3", acq_state_o); end
        if (bus.wr_addr_o !== 3'd4) begin errors++; $display("FAIL post_trig_addr: got %0d want 4", bus.wr_addr_o); end
        pulse(6'b010000);
        recv(0, d, a, w, st);
        checks++;
        if (d !== 8'h06) begin errors++; $display("FAIL stat_done: got %h want 06", d); end
        pulse(6'b100000);
        checks++;
        if (acq_state_o !== 2'd0 || bus.wr_addr_o !== 3'd0) begin
            errors++; $display("FAIL reset_i: state %0d addr %0d want 0 0", acq_state_o, bus.wr_addr_o);
        end
    endtask

    task automatic test_capture();
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int w;
        logic st;
        pulse(6'b000001);
        for (int k = 0; k < 10; k++) sample(k);
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        for (int k = 10; k < 13; k++) sample(k);
        checks++;
        if (acq_state_o !== 2'd2) begin errors++; $display("FAIL cap_trig: state %0d want 2", acq_state_o); end
        sample(13);
        checks += 2;
        if (acq_state_o !== 2'd3) begin errors++; $display("FAIL cap_done: state %0d want 3", acq_state_o); end
        if (bus.wr_addr_o !== 3'd6) begin errors++; $display("FAIL cap_wr_addr: got %0d want 6", bus.wr_addr_o); end
        pulse(6'b000100);
        for (int i = 0; i < 8; i++) begin
            recv(0, d, a, w, st);
            checks += 3;
            if (d !== 8'h16 + 8'(i)) begin errors++; $display("FAIL cap_data[%0d]: got %h want %h", i, d, 8'h16 + 8'(i)); end
            if (a !== 3'(6 + i)) begin errors++; $display("FAIL cap_rd_addr[%0d]: got %0d want %0d", i, a, 3'(6 + i)); end
            if (w !== ((i == 0) ? 3 : 2)) begin errors++; $display("FAIL cap_pace[%0d]: got %0d want %0d", i, w, (i == 0) ? 3 : 2); end
        end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL cap_end_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int w;
        logic st;
        pulse(6'b000100);
        for (int i = 0; i < 8; i++) begin
            recv((i == 3) ? 20 : 0, d, a, w, st);
            checks++;
            if (d !== 8'h16 + 8'(i)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, d, 8'h16 + 8'(i)); end
            if (i == 3) begin
                checks++;
                if (st !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b want 1", st); end
            end
        end
    endtask

    task automatic test_arbitration();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        logic [AW-1:0] a;
        int w;
        logic st;
        pulse(6'b010000);
        tick();
        pulse(6'b001000);
        pulse(6'b010000);
        pulse(6'b000100);
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h06);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h16 + 8'(i));
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h86 + 8'(i));
        for (int i = 0; i < 18; i++) begin
            if (i == 4) begin
                pulse(6'b000001);
                checks++;
                if (acq_state_o !== 2'd3) begin errors++; $display("FAIL arb_start_ignored: state %0d want 3", acq_state_o); end
            end
            recv(0, d, a, w, st);
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL arb_order[%0d]: got %h want %h", i, d, e); end
        end
    endtask

    task automatic test_stop();
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int w;
        int n;
        logic st;
        pulse(6'b000001);
        stop_i = 1'b1;
        trigger_i = 1'b1;
        tick();
        stop_i = 1'b0;
        trigger_i = 1'b0;
        checks++;
        if (acq_state_o !== 2'd0) begin errors++; $display("FAIL stop_trig_state: got %0d want 0", acq_state_o); end
        pulse(6'b010000);
        recv(0, d, a, w, st);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL stop_trig_stat: got %h want 00", d); end
        pulse(6'b000001);
        stop_i = 1'b1;
        rqst_ch1_i = 1'b1;
        tick();
        stop_i = 1'b0;
        rqst_ch1_i = 1'b0;
        checks++;
        if (acq_state_o !== 2'd0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL stop_rqst_edge: state %0d busy %b want 0 0", acq_state_o, busy_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL stop_rqst_start: busy %b want 1", busy_o); end
        pulse(6'b001000);
        n = 0;
        while (bus.tx_rdy_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.tx_rdy_o !== 1'b1) begin errors++; $display("FAIL mid_rdy_timeout: tx_rdy %b want 1", bus.tx_rdy_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.tx_rdy_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL mid_rst: tx_rdy %b busy %b want 0 0", bus.tx_rdy_o, busy_o);
        end
        repeat (5) tick();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_drops_pending: busy %b want 0", busy_o); end
    endtask

    initial begin
        bus.tx_ack_i = 1'b0;
        test_reset();
        test_status();
        test_capture();
        test_back_pressure();
        test_arbitration();
        test_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
